// File: rtl/mem_pkg.sv
// Purpose: shared types and constants for the MEM pipeline stage.
// Latency: n/a (types only).
// Backpressure: n/a.
package mem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    localparam logic LOAD_ZEXT = 1'b0;
    localparam logic LOAD_SEXT = 1'b1;

    // Contents of the MEM->WB pipeline register.
    typedef struct packed {
        logic [29:0] pcp1;
        logic [4:0]  rw;
        logic [31:0] val;
        logic        reg_write;
    } mem_wb_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Purpose: select and extend the addressed byte/halfword of a raw bridge word.
// Latency: purely combinational.
// Backpressure: none.
// Ports: dmout raw word, off address low bits, is_byte/is_half access size,
//        sign extension select, aligned 32-bit result.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] dmout,
    input  logic [1:0]  off,
    input  logic        is_byte,
    input  logic        is_half,
    input  logic        sign,
    output logic [31:0] aligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        sext;

    always_comb begin
        byte_sel = dmout[{off, 3'b000} +: 8];
        // Halfword uses only off[1]; a misaligned half silently rounds down.
        half_sel = off[1] ? dmout[31:16] : dmout[15:0];
        sext     = (sign == LOAD_SEXT);
        aligned  = dmout;
        if (is_byte) begin
            aligned = {{24{sext & byte_sel[7]}}, byte_sel};
        end else if (is_half) begin
            aligned = {{16{sext & half_sel[15]}}, half_sel};
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Purpose: MEM stage - load align, deferred branch resolve, bridge wait/timeout, MEM->WB register.
// Latency: one cycle to wb_*; bypass and branch correction are combinational.
// Backpressure: stall_req holds IF..EX and this stage while a load waits on dm_rdy;
//               after WAIT_MAX stalled cycles the load is dropped and bus_err pulses.
// Ports: EX/MEM control + data in; correct_at_mem/correct_pc_at_mem redirect;
//        stall_req, bus_err; mem_back_* bypass; wb_* registered results.
module mem_stage
    import mem_pkg::*;
#(
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        reg_write,
    input  logic        mem_to_reg,
    input  logic        is_dm_byte,
    input  logic        is_dm_half,
    input  logic        load_sign,
    input  logic [29:0] pcp1,
    input  logic [4:0]  rw,
    input  logic [31:0] exout,
    input  logic [31:0] dmout,
    input  logic        dm_rdy,
    input  logic [2:0]  branch_type,
    input  logic        commit_at_mem,
    input  logic        predict_avail,
    input  logic        ex_branch_avail,
    input  logic [29:0] bpc,
    input  logic [29:0] nojpc,
    output logic        correct_at_mem,
    output logic [31:0] correct_pc_at_mem,
    output logic        stall_req,
    output logic        bus_err,
    output logic        mem_back_we,
    output logic [4:0]  mem_back_rw,
    output logic [31:0] mem_back_val,
    output logic        wb_reg_write,
    output logic [4:0]  wb_rw,
    output logic [31:0] wb_val,
    output logic [29:0] wb_pcp1
);

    mem_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [31:0]      aligned;
    logic [31:0]      result;
    logic             timeout;
    mem_wb_t          wb_q;

    load_align u_align (
        .dmout   (dmout),
        .off     (exout[1:0]),
        .is_byte (is_dm_byte),
        .is_half (is_dm_half),
        .sign    (load_sign),
        .aligned (aligned)
    );

    assign result    = mem_to_reg ? aligned : exout;
    assign stall_req = mem_to_reg & ~dm_rdy & ~flush;
    // Last permitted wait cycle expired with no data and no flush.
    assign timeout   = (state == WAIT) & ~flush & ~dm_rdy & (cnt == CNT_W'(WAIT_MAX - 1));

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (mem_to_reg && !dm_rdy && !flush) begin
                    state_nxt = WAIT;
                    cnt_nxt   = CNT_W'(1);
                end else begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            WAIT: begin
                if (flush || dm_rdy || timeout) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bus_err <= 1'b0;
            wb_q    <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bus_err <= timeout;
            // A squashed, stalled or abandoned instruction becomes a bubble;
            // the data fields keep their old contents.
            if (flush || stall_req || timeout) begin
                wb_q.reg_write <= 1'b0;
            end else begin
                wb_q <= '{pcp1: pcp1, rw: rw, val: result, reg_write: reg_write};
            end
        end
    end

    assign wb_reg_write = wb_q.reg_write;
    assign wb_rw        = wb_q.rw;
    assign wb_val       = wb_q.val;
    assign wb_pcp1      = wb_q.pcp1;

    // Forwarding is suppressed while a load waits, so stale dmout never escapes.
    assign mem_back_we  = reg_write & ~stall_req & ~flush;
    assign mem_back_rw  = rw;
    assign mem_back_val = result;

    assign correct_at_mem    = commit_at_mem & (branch_type != 3'd0) &
                               (predict_avail != ex_branch_avail) & ~flush;
    assign correct_pc_at_mem = {ex_branch_avail ? bpc : nojpc, 2'b00};

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage; sits directly downstream of EX and consumes its EX→MEM register: data, control, branch-commit bundle and raw bridge read word.
- Aligns and extends load data and resolves branches deferred to MEM.
- Inserts wait states for slow bridge reads, with a timeout-driven bus error.
- Publishes the MEM bypass value and registers results into the MEM→WB register.

Parameters:
WAIT_MAX, 16, max wait cycles for dm_rdy before bus error (≥2)
CNT_W, 5, width of wait counter (must hold WAIT_MAX)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
flush  in  1  controller MEM_FLUSH; squashes current instr
reg_write  in  1  WB_CTRL.regWrite from EX/MEM
mem_to_reg  in  1  WB_CTRL.memToReg (load)
is_dm_byte  in  1  byte access
is_dm_half  in  1  halfword access
load_sign  in  1  1 = sign-extend, 0 = zero-extend
pcp1  in  30  PC+4 [31:2]
rw  in  5  destination register
exout  in  32  EX result; load address when mem_to_reg
dmout  in  32  raw word from bridge
dm_rdy  in  1  bridge read data valid
branch_type  in  3  0 = not a branch
commit_at_mem  in  1  branch resolution deferred to MEM
predict_avail  in  1  predicted taken
ex_branch_avail  in  1  actual taken, computed in EX
bpc  in  30  taken target [31:2]
nojpc  in  30  fall-through [31:2]
correct_at_mem  out  1  misprediction redirect
correct_pc_at_mem  out  32  redirect PC
stall_req  out  1  hold IF..EX and this stage
bus_err  out  1  one-cycle timeout pulse
mem_back_we  out  1  bypass valid
mem_back_rw  out  5  bypass register
mem_back_val  out  32  bypass value
wb_reg_write  out  1  MEM→WB regWrite
wb_rw  out  5  MEM→WB dest
wb_val  out  32  MEM→WB result
wb_pcp1  out  30  MEM→WB PC+4

Behaviour:
- Reset (rst=0, asynchronous): every wb_* output = 0; state = IDLE; counter = 0; bus_err = 0. Combinational outputs follow inputs.
- Load align: off = exout[1:0]
  - Byte: dmout[8*off+7 : 8*off], extended per load_sign.
  - Half: off[1] selects bits [31:16] or [15:0], extended per load_sign.
  - Word: dmout unchanged. Misaligned word/half accesses ignore the low address bits (no trap).
- result = mem_to_reg ? aligned : exout.
- FSM states: IDLE, WAIT.
  - IDLE: if mem_to_reg && !dm_rdy && !flush → WAIT, counter = 1. Otherwise capture into WB.
  - WAIT: dm_rdy → capture, → IDLE, counter = 0. Else if counter == WAIT_MAX-1 → bus_err = 1 next cycle, WB gets a bubble (wb_reg_write = 0), → IDLE. Else counter++.
  - flush in either state → IDLE, counter = 0, WB bubble. Flush has priority over dm_rdy and over timeout.
- stall_req = mem_to_reg && !dm_rdy && !flush, in IDLE or WAIT. Combinational, so it drops in the same cycle dm_rdy rises.
- WB register on posedge:
  - flush or stall_req or timeout → wb_reg_write = 0; other wb_* hold.
  - Else wb_reg_write = reg_write, wb_rw = rw, wb_val = result, wb_pcp1 = pcp1.
- Bypass:
  - mem_back_we = reg_write && !stall_req && !flush.
  - mem_back_rw = rw; mem_back_val = result.
  - A pending load never forwards stale data.
- Branch correction:
  - correct_at_mem = commit_at_mem && branch_type != 0 && predict_avail != ex_branch_avail && !flush.
  - correct_pc_at_mem = {ex_branch_avail ? bpc : nojpc, 2'b00}.
- Branches never stall, so correction is independent of the FSM.
- bus_err is registered: a 1-cycle pulse in the cycle after the timeout cycle.

Decomposition:
- Package mem_pkg:
  - mem_state_t enum {IDLE, WAIT}.
  - LOAD_ZEXT / LOAD_SEXT constants.
  - Packed struct mem_wb_t {pcp1, rw, val, reg_write}.
- Sub-module load_align: inputs dmout, off, byte, half, sign; output 32-bit aligned. Purely combinational; reused by the verification model.

Test Plan:
- Byte load, exout = 0x1003, dmout = 0x80FF1234, load_sign = 1, dm_rdy = 1 → wb_val = 0xFFFFFF80, wb_reg_write = 1 next edge, stall_req = 0 throughout.
- Half load, off = 2, dmout = 0x8001ABCD, load_sign = 0 → wb_val = 0x00008001; with load_sign = 1 → 0xFFFF8001.
- Word load with dm_rdy low 3 cycles → stall_req = 1 for 3 cycles, mem_back_we = 0, wb_reg_write = 0 (bubbles); cycle 4 dm_rdy = 1 → wb_val = dmout, state IDLE.
- dm_rdy never rises, WAIT_MAX = 16 → stall_req high 16 cycles, then bus_err pulse of 1 cycle, wb_reg_write = 0, FSM back to IDLE, stall_req follows inputs.
- Deferred branch: commit_at_mem = 1, branch_type = 1, predict = 0, ex_avail = 1, bpc = 0x100 → correct_at_mem = 1, correct_pc_at_mem = 0x400. Same stimulus with flush = 1 → correct_at_mem = 0.
- Async reset asserted mid-WAIT → all wb_* = 0 immediately without a clock edge. After release, a new load completes normally.
